ascon_sigma_seq: RTL and testbench

- Multi-cycle sequencer that applies the Ascon linear diffusion layer (sigma_0..sigma_4) to a full 320-bit Ascon state.
- Uses a single shared 32-bit-output sigma datapath instance, stepping `imm` through words 0..4 and the lo/hi halves of each word.
- Sits beside the rv32 ISE as a coprocessor-style accelerator. The state is loaded and unloaded through valid/ready handshakes.

---
 rtl/ascon_sigma_seq.sv | 210 +++++++++++++++++++++
 tb/tb_ascon_sigma_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_sigma_seq.sv
// Ascon linear diffusion layer (sigma_0..sigma_4) applied to a 320-bit state by a shared 32-bit datapath.
// Latency: handshake cycle 0, out_valid visible at cycle 11 (DUAL=0) or cycle 6 (DUAL=1).
// Backpressure: in_ready only in IDLE or DONE with out_ready; out_state held stable while out_ready is low.

// Sigma datapath slice: one 32-bit half of sigma_imm applied to the 64-bit word {rs2, rs1}.
// Purely combinational, zero latency.
// No backpressure; word indices 5..7 produce zero.
module ascon_sigma_dp (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  imm,
    input  logic        op_hi,
    output logic [31:0] rd
);

    logic [63:0] x;
    logic [63:0] y;

    assign x = {rs2, rs1};

    // y = x ^ ror(x, r0) ^ ror(x, r1), rotations written as fixed slices per word
    always_comb begin
        y = '0;
        case (imm)
            3'd0: y = x ^ {x[18:0], x[63:19]} ^ {x[27:0], x[63:28]};
            3'd1: y = x ^ {x[60:0], x[63:61]} ^ {x[38:0], x[63:39]};
            3'd2: y = x ^ {x[0],    x[63:1]}  ^ {x[5:0],  x[63:6]};
            3'd3: y = x ^ {x[9:0],  x[63:10]} ^ {x[16:0], x[63:17]};
            3'd4: y = x ^ {x[6:0],  x[63:7]}  ^ {x[40:0], x[63:41]};
            default: y = '0;
        endcase
    end

    assign rd = op_hi ? y[63:32] : y[31:0];

endmodule

module ascon_sigma_seq #(
    parameter int DUAL = 0
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t              fsm;
    logic [4:0][63:0]  state_buf;
    logic [2:0]        word_idx;
    logic              half;
    logic [31:0]       lo_temp;
    logic              out_vld_q;

    logic [63:0]       sel_word;
    logic [31:0]       dp_a;
    logic [31:0]       dp_b;
    logic [63:0]       wb_word;
    logic              last_word;

    // Operand word for the current step, always read from the untouched buffer entry
    always_comb begin
        sel_word = '0;
        case (word_idx)
            3'd0: sel_word = state_buf[0];
            3'd1: sel_word = state_buf[1];
            3'd2: sel_word = state_buf[2];
            3'd3: sel_word = state_buf[3];
            3'd4: sel_word = state_buf[4];
            default: sel_word = '0;
        endcase
    end

    generate
        if (DUAL != 0) begin : g_dual
            ascon_sigma_dp u_dp_lo (
                .rs1   (sel_word[31:0]),
                .rs2   (sel_word[63:32]),
                .imm   (word_idx),
                .op_hi (1'b0),
                .rd    (dp_a)
            );
            ascon_sigma_dp u_dp_hi (
                .rs1   (sel_word[31:0]),
                .rs2   (sel_word[63:32]),
                .imm   (word_idx),
                .op_hi (1'b1),
                .rd    (dp_b)
            );
        end else begin : g_single
            // One slice: lo half when half=0, hi half when half=1
            ascon_sigma_dp u_dp (
                .rs1   (sel_word[31:0]),
                .rs2   (sel_word[63:32]),
                .imm   (word_idx),
                .op_hi (half),
                .rd    (dp_a)
            );
            assign dp_b = '0;
        end
    endgenerate

    // Word written back: both halves at once, never a lone lo half over the original word
    always_comb begin
        wb_word = '0;
        if (DUAL != 0) begin
            wb_word = {dp_b, dp_a};
        end else begin
            wb_word = {dp_a, lo_temp};
        end
    end

    assign last_word = (word_idx == 3'd4);

    assign in_ready  = (fsm == S_IDLE) || ((fsm == S_DONE) && out_ready);
    assign out_valid = out_vld_q;
    assign out_state = state_buf;
    assign busy      = (fsm == S_RUN);

    // Sequencer: load, step through words/halves, hold result until consumed
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fsm       <= S_IDLE;
            state_buf <= '0;
            word_idx  <= '0;
            half      <= 1'b0;
            lo_temp   <= '0;
            out_vld_q <= 1'b0;
        end else if (flush) begin
            fsm       <= S_IDLE;
            word_idx  <= '0;
            half      <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        state_buf <= in_state;
                        word_idx  <= '0;
                        half      <= 1'b0;
                        fsm       <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (word_idx > 3'd4) begin
                        // Unreachable index: abandon the job rather than write garbage
                        fsm      <= S_IDLE;
                        word_idx <= '0;
                        half     <= 1'b0;
                    end else if ((DUAL == 0) && !half) begin
                        lo_temp <= dp_a;
                        half    <= 1'b1;
                    end else begin
                        case (word_idx)
                            3'd0: state_buf[0] <= wb_word;
                            3'd1: state_buf[1] <= wb_word;
                            3'd2: state_buf[2] <= wb_word;
                            3'd3: state_buf[3] <= wb_word;
                            3'd4: state_buf[4] <= wb_word;
                            default: ;
                        endcase
                        half <= 1'b0;
                        if (last_word) begin
                            word_idx  <= '0;
                            fsm       <= S_DONE;
                            out_vld_q <= 1'b1;
                        end else begin
                            word_idx <= word_idx + 3'd1;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_vld_q <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back job: reload in the same cycle the result leaves
                            state_buf <= in_state;
                            word_idx  <= '0;
                            half      <= 1'b0;
                            fsm       <= S_RUN;
                        end else begin
                            fsm <= S_IDLE;
                        end
                    end
                end

                default: begin
                    fsm       <= S_IDLE;
                    word_idx  <= '0;
                    half      <= 1'b0;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_sigma_seq.sv
// Bench for ascon_sigma_seq: instance 0 built with DUAL=0, instance 1 with DUAL=1.
// Directed latency/stall/flush/reset scenarios plus randomised traffic, checked against a reference sigma.
// A negedge monitor predicts every result and compares out_state on each cycle out_valid is high.
module tb_ascon_sigma_seq;

    logic         g_clk;
    logic [1:0]   g_resetn;
    logic [1:0]   flush;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [319:0] in_st  [2];
    logic [1:0]   out_valid;
    logic [1:0]   out_ready;
    logic [319:0] out_st [2];
    logic [1:0]   busy;

    int checks = 0;
    int errors = 0;

    // expected-result ring per instance
    logic [319:0] exp_mem [2][8];
    int           head [2];
    int           tail [2];

    ascon_sigma_seq #(.DUAL(0)) u_dut0 (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn[0]),
        .flush     (flush[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_state  (in_st[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_state (out_st[0]),
        .busy      (busy[0])
    );

    ascon_sigma_seq #(.DUAL(1)) u_dut1 (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn[1]),
        .flush     (flush[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_state  (in_st[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_state (out_st[1]),
        .busy      (busy[1])
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Reference: plain rotate-by-shift arithmetic on each 64-bit word
    function automatic logic [63:0] ref_sigma(input logic [63:0] x, input int i);
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        logic [63:0] a;
        logic [63:0] b;
        a = (x >> ra[i]) | (x << (64 - ra[i]));
        b = (x >> rb[i]) | (x << (64 - rb[i]));
        return x ^ a ^ b;
    endfunction

    function automatic logic [319:0] ref_state(input logic [319:0] s);
        logic [319:0] r;
        for (int i = 0; i < 5; i++) r[64*i +: 64] = ref_sigma(s[64*i +: 64], i);
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: predict results on accepted inputs, compare out_state whenever valid
    always @(negedge g_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!g_resetn[d] || flush[d]) begin
                head[d] = tail[d];
            end else begin
                if (out_valid[d]) begin
                    if (head[d] == tail[d]) begin
                        chk($sformatf("d%0d_unexpected_out_valid", d), out_valid[d], 0);
                    end else begin
                        chk($sformatf("d%0d_out_state", d), out_st[d], exp_mem[d][head[d] % 8]);
                        if (out_ready[d]) head[d] = head[d] + 1;
                    end
                end
                if (in_valid[d] && in_ready[d]) begin
                    exp_mem[d][tail[d] % 8] = ref_state(in_st[d]);
                    tail[d] = tail[d] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic send(input int d, input logic [319:0] s);
        bit acc;
        acc = 1'b0;
        in_valid[d] = 1'b1;
        in_st[d] = s;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge g_clk);
            acc = in_ready[d];
            tick();
        end
        in_valid[d] = 1'b0;
        chk($sformatf("d%0d_send_accepted", d), acc, 1);
    endtask

    task automatic wait_valid(input int d);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge g_clk);
            seen = out_valid[d];
            tick();
        end
        chk($sformatf("d%0d_out_valid_seen", d), seen, 1);
    endtask

    task automatic accept(input int d);
        out_ready[d] = 1'b1;
        @(negedge g_clk);
        tick();
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic [319:0] ones;
        logic [319:0] st_a;
        logic [319:0] st_b;
        int lat;
        int sent;
        int got;
        int cyc;
        bit acc;

        for (int d = 0; d < 2; d++) begin
            head[d] = 0;
            tail[d] = 0;
            in_st[d] = '0;
        end
        g_resetn  = 2'b00;
        flush     = 2'b00;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        #22;
        g_resetn = 2'b11;
        tick();

        // Hand-computed words pin the reference model
        chk("model_w0", ref_sigma(64'h1, 0), 64'h0000_2010_0000_0001);
        chk("model_w1", ref_sigma(64'h1, 1), 64'h0000_0000_0200_0009);
        chk("model_w2", ref_sigma(64'h1, 2), 64'h8400_0000_0000_0001);
        chk("model_w3", ref_sigma(64'h1, 3), 64'h0040_8000_0000_0001);
        chk("model_w4", ref_sigma(64'h1, 4), 64'h0200_0000_0080_0001);

        ones = {5{64'h0000_0000_0000_0001}};

        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 10 : 5;

            // reset state
            chk($sformatf("d%0d_rst_in_ready", d), in_ready[d], 1);
            chk($sformatf("d%0d_rst_out_valid", d), out_valid[d], 0);
            chk($sformatf("d%0d_rst_busy", d), busy[d], 0);
            chk($sformatf("d%0d_rst_out_state", d), out_st[d], 0);

            // latency with a zero state
            in_valid[d] = 1'b1;
            in_st[d] = '0;
            @(negedge g_clk);
            chk($sformatf("d%0d_lat_in_ready_c0", d), in_ready[d], 1);
            tick();
            in_valid[d] = 1'b0;
            for (int c = 1; c <= lat + 2; c++) begin
                @(negedge g_clk);
                chk($sformatf("d%0d_busy_c%0d", d, c), busy[d], (c <= lat));
                chk($sformatf("d%0d_out_valid_c%0d", d, c), out_valid[d], (c > lat));
                if (c > lat) chk($sformatf("d%0d_zero_result_c%0d", d, c), out_st[d], 0);
                tick();
            end
            accept(d);

            // all-ones-word state against literal words
            send(d, ones);
            wait_valid(d);
            chk($sformatf("d%0d_ones_w0", d), out_st[d][63:0],    64'h0000_2010_0000_0001);
            chk($sformatf("d%0d_ones_w1", d), out_st[d][127:64],  64'h0000_0000_0200_0009);
            chk($sformatf("d%0d_ones_w2", d), out_st[d][191:128], 64'h8400_0000_0000_0001);
            chk($sformatf("d%0d_ones_w3", d), out_st[d][255:192], 64'h0040_8000_0000_0001);
            chk($sformatf("d%0d_ones_w4", d), out_st[d][319:256], 64'h0200_0000_0080_0001);
            accept(d);

            // long output stall, then zero-bubble hand-over
            st_a = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'hdead_beef_cafe_f00d,
                    64'h8000_0000_0000_0001, 64'hffff_ffff_0000_0000};
            st_b = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc,
                    64'hdddd_eeee_ffff_0000, 64'h0f0f_f0f0_a5a5_5a5a};
            send(d, st_a);
            wait_valid(d);
            in_valid[d] = 1'b1;
            in_st[d] = st_b;
            for (int c = 0; c < 20; c++) begin
                @(negedge g_clk);
                chk($sformatf("d%0d_stall_state_%0d", d, c), out_st[d], ref_state(st_a));
                chk($sformatf("d%0d_stall_in_ready_%0d", d, c), in_ready[d], 0);
                chk($sformatf("d%0d_stall_valid_%0d", d, c), out_valid[d], 1);
                tick();
            end
            out_ready[d] = 1'b1;
            @(negedge g_clk);
            chk($sformatf("d%0d_handover_in_ready", d), in_ready[d], 1);
            tick();
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            @(negedge g_clk);
            chk($sformatf("d%0d_handover_busy", d), busy[d], 1);
            chk($sformatf("d%0d_handover_valid", d), out_valid[d], 0);
            tick();
            wait_valid(d);
            chk($sformatf("d%0d_second_job", d), out_st[d], ref_state(st_b));
            accept(d);

            // flush at cycle 4 of RUN with a competing in_valid
            in_valid[d] = 1'b1;
            in_st[d] = st_a;
            @(negedge g_clk);
            tick();
            in_valid[d] = 1'b0;
            tick();
            tick();
            tick();
            flush[d] = 1'b1;
            in_valid[d] = 1'b1;
            in_st[d] = st_b;
            @(negedge g_clk);
            tick();
            flush[d] = 1'b0;
            in_valid[d] = 1'b0;
            @(negedge g_clk);
            chk($sformatf("d%0d_flush_busy", d), busy[d], 0);
            chk($sformatf("d%0d_flush_in_ready", d), in_ready[d], 1);
            tick();
            for (int c = 0; c < 15; c++) begin
                @(negedge g_clk);
                chk($sformatf("d%0d_flush_no_valid_%0d", d, c), out_valid[d], 0);
                tick();
            end
            send(d, ones);
            wait_valid(d);
            chk($sformatf("d%0d_after_flush", d), out_st[d], ref_state(ones));
            accept(d);

            // asynchronous reset mid-RUN
            send(d, st_b);
            tick();
            #2;
            g_resetn[d] = 1'b0;
            #1;
            chk($sformatf("d%0d_arst_valid", d), out_valid[d], 0);
            chk($sformatf("d%0d_arst_in_ready", d), in_ready[d], 1);
            chk($sformatf("d%0d_arst_busy", d), busy[d], 0);
            chk($sformatf("d%0d_arst_state", d), out_st[d], 0);
            #3;
            g_resetn[d] = 1'b1;
            tick();
            send(d, st_a);
            wait_valid(d);
            chk($sformatf("d%0d_after_arst", d), out_st[d], ref_state(st_a));
            accept(d);

            // randomised traffic with stalls on both sides
            sent = 0;
            got = 0;
            cyc = 0;
            while (got < 1000 && cyc < 30000) begin
                out_ready[d] = ($urandom_range(0, 3) != 0);
                if (!in_valid[d] && sent < 1000 && $urandom_range(0, 3) != 0) begin
                    in_valid[d] = 1'b1;
                    in_st[d] = rand320();
                end
                @(negedge g_clk);
                acc = in_valid[d] && in_ready[d];
                if (out_valid[d] && out_ready[d]) got++;
                tick();
                cyc++;
                if (acc) begin
                    in_valid[d] = 1'b0;
                    sent++;
                end
            end
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            chk($sformatf("d%0d_rand_sent", d), sent, 1000);
            chk($sformatf("d%0d_rand_got", d), got, 1000);
            chk($sformatf("d%0d_no_leftover", d), tail[d] - head[d], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
